// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types and constants for the UART command assembler.
// Optional checksum byte is enabled by defining CMD_CKSUM_EN.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    OPC  = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CKS  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         BAUD_CLKS     = 5208;
  localparam int         TIMEOUT_DEF   = 20 * BAUD_CLKS;

  // Modulo-256 sum of a checksummed frame body; zero means the frame is good.
  function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
    frame_sum = a + b + c + d;
  endfunction

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / command-out bundle between receiver, assembler and consumer.
//
// Handshakes:
//  - Byte side: rdy is a level held by the receiver while rx_data is valid;
//    the assembler takes the byte in a cycle where rdy=1 and clr_rdy=0, and
//    answers with a single-cycle clr_rdy on the following cycle.
//  - Command side: cmd_vld stays high with cmd_opcode/cmd_data stable until
//    the consumer raises cmd_ack in a cycle where cmd_vld=1; cmd_vld drops on
//    the next cycle. cmd_ack with cmd_vld=0 has no effect.
interface uart_cmd_if;
  logic        rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic        cmd_vld;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_data;
  logic        cmd_ack;
  logic        frm_err;
  logic        cmd_ovr;

  // Receiver + command consumer side
  modport master (
    output rdy, rx_data, cmd_ack,
    input  clr_rdy, cmd_vld, cmd_opcode, cmd_data, frm_err, cmd_ovr
  );

  // Assembler side
  modport slave (
    input  rdy, rx_data, cmd_ack,
    output clr_rdy, cmd_vld, cmd_opcode, cmd_data, frm_err, cmd_ovr
  );
endinterface

// File: rtl/uart_cmd_assembler_gap_timer.sv
// Inter-byte gap timer: counts clocks while enabled, cleared by each accepted
// byte, and flags the cycle in which the gap limit is reached.
module uart_gap_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] count;

  // Count idle clocks inside a frame; held at zero while hunting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // A byte accepted in the limit cycle wins over the timeout.
  assign timeout = en & ~clr & (count == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Frame assembler: hunts for the sync byte, collects opcode and 16-bit data
// (plus a checksum byte when CMD_CKSUM_EN is defined) and presents the
// finished command on a valid/ack port. Reports timeouts and overruns.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_if.slave    bus,
  output state_t       dbg_state
);

  state_t      state, state_nxt;
  logic        take;
  logic        timeout;
  logic        ld_opc, ld_dhi;
  logic        complete;
  logic        cks_fail;
  logic [7:0]  opc_q, dhi_q;
  logic [15:0] new_data;
`ifdef CMD_CKSUM_EN
  logic        ld_dlo;
  logic [7:0]  dlo_q;
`endif

  // clr_rdy masks the byte for the one cycle rdy lingers after acknowledge.
  assign take      = bus.rdy & ~bus.clr_rdy;
  assign dbg_state = state;

  uart_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (take),
    .en      (state != HUNT),
    .timeout (timeout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next state and per-byte load strobes; bytes only move the FSM on take.
  always_comb begin
    state_nxt = state;
    ld_opc    = 1'b0;
    ld_dhi    = 1'b0;
    complete  = 1'b0;
    cks_fail  = 1'b0;
`ifdef CMD_CKSUM_EN
    ld_dlo    = 1'b0;
    new_data  = {dhi_q, dlo_q};
`else
    new_data  = {dhi_q, bus.rx_data};
`endif
    if (timeout) begin
      state_nxt = HUNT;
    end else if (take) begin
      case (state)
        HUNT: if (bus.rx_data == SYNC_BYTE) state_nxt = OPC;
        OPC: begin
          ld_opc    = 1'b1;
          state_nxt = DHI;
        end
        DHI: begin
          ld_dhi    = 1'b1;
          state_nxt = DLO;
        end
`ifdef CMD_CKSUM_EN
        DLO: begin
          ld_dlo    = 1'b1;
          state_nxt = CKS;
        end
        CKS: begin
          if (frame_sum(opc_q, dhi_q, dlo_q, bus.rx_data) == 8'h00) complete = 1'b1;
          else                                                       cks_fail = 1'b1;
          state_nxt = HUNT;
        end
`else
        DLO: begin
          complete  = 1'b1;
          state_nxt = HUNT;
        end
`endif
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Partial-frame holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q <= '0;
      dhi_q <= '0;
`ifdef CMD_CKSUM_EN
      dlo_q <= '0;
`endif
    end else begin
      if (ld_opc) opc_q <= bus.rx_data;
      if (ld_dhi) dhi_q <= bus.rx_data;
`ifdef CMD_CKSUM_EN
      if (ld_dlo) dlo_q <= bus.rx_data;
`endif
    end
  end

  // Output registers: byte acknowledge, command hold, error/overrun pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.clr_rdy    <= 1'b0;
      bus.cmd_vld    <= 1'b0;
      bus.cmd_opcode <= '0;
      bus.cmd_data   <= '0;
      bus.frm_err    <= 1'b0;
      bus.cmd_ovr    <= 1'b0;
    end else begin
      bus.clr_rdy <= take;
      bus.frm_err <= timeout | cks_fail;
      bus.cmd_ovr <= complete & bus.cmd_vld & ~bus.cmd_ack;
      if (complete && (!bus.cmd_vld || bus.cmd_ack)) begin
        bus.cmd_vld    <= 1'b1;
        bus.cmd_opcode <= opc_q;
        bus.cmd_data   <= new_data;
      end else if (bus.cmd_ack) begin
        bus.cmd_vld <= 1'b0;
      end
    end
  end

endmodule
